// File: rtl/spi_init_loader.sv
// ---------------------------------------------------------------------------
// spi_init_loader
//
// SPI mode-0 slave that receives LCD init-sequence words from the ESP32,
// queues them in a small FIFO and presents them to the LCD controller's init
// port over a rdy/ack handshake. SCLK, MOSI and CS are synchronised into
// i_clk, so everything runs in the system clock domain (SCLK <= i_clk/8).
//
// Optional build macro:
//   SPI_STATUS_READBACK_EN  - when defined, a new CS frame shifts out a status
//                             word {overflow, done, magic_seen, end_queued,
//                             zero pad, fifo_level}; otherwise it echoes the
//                             last completed word (0 after reset).
//                             Requires WORD_BITS >= $clog2(FIFO_DEPTH)+5.
//
// Ports:
//   i_clk, i_reset      system clock, async active-high reset
//   i_spi_clk/mosi/cs   SPI slave pins (CS active-low), async to i_clk
//   o_spi_miso(_oe)     readback data and its output enable (= CS active)
//   o_init_data/rdy     FIFO head payload and its valid
//   i_init_ack          consumer takes the head word while rdy is high
//   o_init_done         end marker reached the FIFO head (sticky)
//   o_magic_seen        MAGIC word received (sticky)
//   o_overflow          a word was dropped on a full FIFO (sticky)
//   o_fifo_level        current FIFO occupancy, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module spi_init_loader #(
    parameter int                   WORD_BITS  = 16,
    parameter int                   DATA_BITS  = 9,
    parameter int                   FIFO_DEPTH = 8,
    parameter logic [WORD_BITS-1:0] MAGIC      = 16'hCAFE
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_spi_clk,
    input  logic                            i_spi_mosi,
    input  logic                            i_spi_cs,
    output logic                            o_spi_miso,
    output logic                            o_spi_miso_oe,
    output logic [DATA_BITS-1:0]            o_init_data,
    output logic                            o_init_rdy,
    input  logic                            i_init_ack,
    output logic                            o_init_done,
    output logic                            o_magic_seen,
    output logic                            o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int CNT_W   = $clog2(WORD_BITS);
    localparam int ENTRY_W = DATA_BITS + 1;   // {is_end, payload}

    // -----------------------------------------------------------------------
    // Synchronisers. Index [1] is the synchronised level; [2] is the delayed
    // copy used for edge detection. CS resets to idle (high) so the MISO
    // enable is low in reset.
    // -----------------------------------------------------------------------
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] cs_sync_q,   cs_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;

    logic sclk_rise, sclk_fall, cs_active, cs_fall, mosi_s;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], i_spi_clk};
        cs_sync_d   = {cs_sync_q[1:0],   i_spi_cs};
        mosi_sync_d = {mosi_sync_q[0],   i_spi_mosi};
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_active = ~cs_sync_q[1];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign mosi_s    = mosi_sync_q[1];

    // -----------------------------------------------------------------------
    // Sticky flags and FIFO state (declared early; readback needs them).
    // -----------------------------------------------------------------------
    logic               magic_q,   magic_d;
    logic               ovf_q,     ovf_d;
    logic               done_q,    done_d;
    logic               endq_q,    endq_d;
    logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [LVL_W-1:0]   level_q,   level_d;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];

    // -----------------------------------------------------------------------
    // Shift engine
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] rx_q,      rx_d;
    logic [WORD_BITS-1:0] tx_q,      tx_d;
    logic                 word_vld_q, word_vld_d;
    logic [WORD_BITS-1:0] readback;
    logic [CNT_W-1:0]     cnt_base;

`ifdef SPI_STATUS_READBACK_EN
    always_comb begin
        readback                  = '0;
        readback[WORD_BITS-1]     = ovf_q;
        readback[WORD_BITS-2]     = done_q;
        readback[WORD_BITS-3]     = magic_q;
        readback[WORD_BITS-4]     = endq_q;
        readback[LVL_W-1:0]       = level_q;
    end
`else
    logic [WORD_BITS-1:0] last_word_q, last_word_d;
    assign readback = last_word_q;
`endif

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        word_vld_d = 1'b0;
`ifndef SPI_STATUS_READBACK_EN
        last_word_d = last_word_q;
`endif
        // A CS fall restarts the word even if an edge lands in the same cycle.
        cnt_base = cs_fall ? '0 : bit_cnt_q;

        if (!cs_active) begin
            // Idle CS keeps the counter at 0: a partial word simply vanishes.
            bit_cnt_d = '0;
        end else begin
            if (cs_fall) begin
                bit_cnt_d = '0;
                tx_d      = readback;
            end
            if (sclk_rise) begin
                rx_d = {rx_q[WORD_BITS-2:0], mosi_s};
                if (cnt_base == CNT_W'(WORD_BITS - 1)) begin
                    // Wrap so back-to-back words work inside one frame.
                    bit_cnt_d  = '0;
                    word_vld_d = 1'b1;
`ifndef SPI_STATUS_READBACK_EN
                    last_word_d = rx_d;
`endif
                end else begin
                    bit_cnt_d = cnt_base + CNT_W'(1);
                end
            end else if (sclk_fall && !cs_fall) begin
                tx_d = {tx_q[WORD_BITS-2:0], 1'b0};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Decode and FIFO. rx_q still holds the completed word in the cycle after
    // the last rising edge, since the next SCLK edge is several cycles away.
    // -----------------------------------------------------------------------
    logic               push_req, push, pop, pop_ack, pop_end;
    logic               head_vld, head_is_end, full, rdy;
    logic [ENTRY_W-1:0] push_entry, head;

    assign head        = mem_q[rd_ptr_q];
    assign head_vld    = (level_q != '0);
    assign head_is_end = head[DATA_BITS];
    assign full        = (level_q == LVL_W'(FIFO_DEPTH));
    assign rdy         = head_vld & ~head_is_end & ~done_q;
    assign pop_ack     = rdy & i_init_ack;
    // The end marker is consumed internally as soon as it reaches the head.
    assign pop_end     = head_vld & head_is_end & ~done_q;
    assign pop         = pop_ack | pop_end;

    always_comb begin
        push_req   = 1'b0;
        push_entry = {rx_q[WORD_BITS-1], rx_q[DATA_BITS-1:0]};
        if (word_vld_q) begin
            if (rx_q == MAGIC) begin
                push_req = 1'b0;
            end else if (endq_q || done_q) begin
                push_req = 1'b0;
            end else begin
                push_req = 1'b1;
            end
        end
    end

    // A pop in the same cycle frees a slot for a push onto a full FIFO.
    assign push = push_req & (~full | pop);

    always_comb begin
        magic_d  = magic_q | (word_vld_q && rx_q == MAGIC);
        ovf_d    = ovf_q | (push_req & ~push);
        endq_d   = endq_q | (push & push_entry[DATA_BITS]);
        done_d   = done_q | pop_end;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            word_vld_q  <= 1'b0;
`ifndef SPI_STATUS_READBACK_EN
            last_word_q <= '0;
`endif
            magic_q     <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            endq_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            mem_q       <= '{default: '0};
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            word_vld_q  <= word_vld_d;
`ifndef SPI_STATUS_READBACK_EN
            last_word_q <= last_word_d;
`endif
            magic_q     <= magic_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            endq_q      <= endq_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            mem_q       <= mem_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_spi_miso    = tx_q[WORD_BITS-1];
    assign o_spi_miso_oe = cs_active;
    assign o_init_rdy    = rdy;
    assign o_init_data   = rdy ? head[DATA_BITS-1:0] : '0;
    assign o_init_done   = done_q;
    assign o_magic_seen  = magic_q;
    assign o_overflow    = ovf_q;
    assign o_fifo_level  = level_q;

endmodule

// File: tb/tb_spi_init_loader.sv
module tb_spi_init_loader;

    localparam int DEPTH = 8;
    localparam int HALF  = 6;   // SCLK half period in i_clk cycles (SCLK = clk/12)

    logic       clk = 1'b0;
    logic       rst, sclk, mosi, cs, ack;
    logic       miso, miso_oe, rdy, done, magic, ovf;
    logic [8:0] data;
    logic [3:0] level;

    always #5 clk = ~clk;

    spi_init_loader dut (
        .i_clk(clk), .i_reset(rst),
        .i_spi_clk(sclk), .i_spi_mosi(mosi), .i_spi_cs(cs),
        .o_spi_miso(miso), .o_spi_miso_oe(miso_oe),
        .o_init_data(data), .o_init_rdy(rdy), .i_init_ack(ack),
        .o_init_done(done), .o_magic_seen(magic), .o_overflow(ovf),
        .o_fifo_level(level)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: queue of entries + sticky flags ------
    typedef struct packed { logic is_end; logic [8:0] pl; } ent_t;
    ent_t mq[$];
    bit   m_magic, m_done, m_ovf, m_endq;

    function automatic void model_reset();
        mq.delete();
        m_magic = 0; m_done = 0; m_ovf = 0; m_endq = 0;
    endfunction

    function automatic void model_settle();
        while (mq.size() > 0 && mq[0].is_end && !m_done) begin
            void'(mq.pop_front());
            m_done = 1;
        end
    endfunction

    function automatic void model_word(input logic [15:0] w);
        ent_t e;
        if (w == 16'hCAFE) m_magic = 1;
        else if (m_endq || m_done) begin end
        else if (mq.size() == DEPTH) m_ovf = 1;
        else begin
            e.is_end = w[15];
            e.pl     = w[8:0];
            mq.push_back(e);
            if (w[15]) m_endq = 1;
        end
        model_settle();
    endfunction

    function automatic bit model_rdy();
        return mq.size() > 0 && !mq[0].is_end && !m_done;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(mq.size()));
        chk({tag, ".rdy"},   32'(rdy),   32'(model_rdy()));
        if (model_rdy()) chk({tag, ".data"}, 32'(data), 32'(mq[0].pl));
        chk({tag, ".magic"}, 32'(magic), 32'(m_magic));
        chk({tag, ".done"},  32'(done),  32'(m_done));
        chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    endtask

    // ---------------- SPI driver ---------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1; cs = 1; sclk = 0; mosi = 0; ack = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        model_reset();
    endtask

    task automatic frame_begin();
        cs = 0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clk);
        cs = 1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [15:0] w, input int nbits, output logic [15:0] rb);
        rb = '0;
        for (int i = 15; i > 15 - nbits; i--) begin
            mosi = w[i];
            repeat (HALF) @(negedge clk);
            rb[i] = miso;      // master samples MISO on the rising edge
            sclk = 1;
            repeat (HALF) @(negedge clk);
            sclk = 0;
        end
    endtask

    task automatic spi_word(input logic [15:0] w, output logic [15:0] rb);
        spi_bits(w, 16, rb);
    endtask

    task automatic send_one(input logic [15:0] w);
        logic [15:0] rb;
        frame_begin();
        spi_word(w, rb);
        frame_end();
        model_word(w);
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        chk({tag, ".ack_rdy"}, 32'(rdy), 32'(model_rdy()));
        if (model_rdy()) chk({tag, ".ack_data"}, 32'(data), 32'(mq[0].pl));
        ack = 1;
        @(negedge clk);
        ack = 0;
        if (model_rdy()) void'(mq.pop_front());
        model_settle();
        repeat (3) @(negedge clk);
    endtask

    // ---------------- ack-high monitor ---------------------------------------
    bit         mon_en = 0;
    logic [8:0] got[$];
    always @(negedge clk) if (mon_en && rdy && ack) got.push_back(data);

    // ---------------- table ---------------------------------------------------
    typedef struct {
        logic [15:0] word;
        int          lvl;
        bit          magic;
        bit          ovf;
    } vec_t;
    vec_t vt[10];

    logic [15:0] rb;

    initial begin
        for (int i = 0; i < 9; i++) begin
            vt[i].word  = 16'(i + 1);
            vt[i].lvl   = (i < 8) ? i + 1 : 8;
            vt[i].magic = 0;
            vt[i].ovf   = (i == 8);
        end
        vt[9] = '{16'hCAFE, 8, 1'b1, 1'b1};

        rst = 1; cs = 1; sclk = 0; mosi = 0; ack = 0;
        do_reset();

        // reset state
        chk("rst.level", 32'(level), 0);
        chk("rst.rdy",   32'(rdy),   0);
        chk("rst.oe",    32'(miso_oe), 0);
        chk("rst.flags", {29'd0, done, magic, ovf}, 0);

        // stream with ack tied high
        ack = 1; mon_en = 1;
        frame_begin();
        spi_word(16'h0012, rb);
        spi_word(16'h0155, rb);
        spi_word(16'h8000, rb);
        frame_end();
        repeat (4) @(negedge clk);
        mon_en = 0; ack = 0;
        chk("ackhi.count", 32'(got.size()), 2);
        chk("ackhi.d0",    32'(got[0]), 32'h012);
        chk("ackhi.d1",    32'(got[1]), 32'h155);
        chk("ackhi.done",  32'(done), 1);
        chk("ackhi.ovf",   32'(ovf),  0);

        // table: 9 data words then MAGIC, ack held low
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send_one(vt[i].word);
            chk($sformatf("tbl%0d.level", i), 32'(level), 32'(vt[i].lvl));
            chk($sformatf("tbl%0d.magic", i), 32'(magic), 32'(vt[i].magic));
            chk($sformatf("tbl%0d.ovf", i),   32'(ovf),   32'(vt[i].ovf));
            chk($sformatf("tbl%0d.done", i),  32'(done),  0);
            chk($sformatf("tbl%0d.head", i),  32'(data),  32'h001);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d.data", i), 32'(data), 32'(i + 1));
            ack = 1; @(negedge clk); ack = 0;
        end
        @(negedge clk);
        chk("drain.rdy",   32'(rdy),   0);
        chk("drain.level", 32'(level), 0);

        // partial word then CS rise, then a full word
        do_reset();
        frame_begin();
        spi_bits(16'hFFFF, 8, rb);
        frame_end();
        send_one(16'h0077);
        chk("partial.level", 32'(level), 1);
        chk("partial.data",  32'(data),  32'h077);
        check_state("partial");

        // end marker behind two data words
        do_reset();
        frame_begin();
        spi_word(16'h0003, rb); model_word(16'h0003);
        spi_word(16'h0004, rb); model_word(16'h0004);
        spi_word(16'h8000, rb); model_word(16'h8000);
        frame_end();
        chk("endq.level", 32'(level), 3);
        chk("endq.done0", 32'(done),  0);
        do_ack("endq.a1");
        chk("endq.done1", 32'(done),  0);
        do_ack("endq.a2");
        chk("endq.done2", 32'(done),  1);
        chk("endq.rdy",   32'(rdy),   0);
        send_one(16'h0001);
        chk("endq.ignored", 32'(level), 0);
        check_state("endq");

        // MISO readback
        do_reset();
        frame_begin();
        spi_word(16'h0011, rb); model_word(16'h0011);
        spi_word(16'h0022, rb); model_word(16'h0022);
        spi_word(16'h0155, rb); model_word(16'h0155);
        frame_end();
        frame_begin();
        chk("rb.oe", 32'(miso_oe), 1);
        spi_word(16'h0000, rb); model_word(16'h0000);
        frame_end();
`ifdef SPI_STATUS_READBACK_EN
        chk("rb.word", 32'(rb), 32'h0003);
`else
        chk("rb.word", 32'(rb), 32'h0155);
`endif
        chk("rb.oe_idle", 32'(miso_oe), 0);
        check_state("rb");

        // reset in the middle of a frame
        send_one(16'hCAFE);
        frame_begin();
        spi_bits(16'hFFFF, 8, rb);
        @(negedge clk); rst = 1;
        repeat (2) @(negedge clk);
        chk("midrst.outs", {miso, miso_oe, rdy, done, magic, ovf, level, data}, 0);
        cs = 1; sclk = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (4) @(negedge clk);
        model_reset();
        check_state("midrst.after");

        // randomized frames against the model
        do_reset();
        for (int f = 0; f < 40; f++) begin
            int nw;
            nw = $urandom_range(1, 3);
            frame_begin();
            for (int k = 0; k < nw; k++) begin
                logic [15:0] w;
                int r;
                r = $urandom_range(0, 99);
                if (r < 6)       w = 16'hCAFE;
                else if (r < 9)  w = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
                else             w = 16'($urandom_range(0, 16'h7FFF));
                spi_word(w, rb);
                model_word(w);
            end
            frame_end();
            check_state($sformatf("rnd%0d", f));
            for (int a = $urandom_range(0, 2); a > 0; a--) begin
                if (model_rdy()) do_ack($sformatf("rnd%0d", f));
            end
            if (m_done && $urandom_range(0, 1) == 1) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_init_loader.md
Name: spi_init_loader

Overview:
Parametrised SPI slave that receives init-sequence words from the ESP32 and buffers them in a FIFO. It presents the words to the LCD controller's init port over a rdy/ack handshake. It replaces the ad-hoc SPI-clocked receiver: all SPI pins are synchronised into the system clock and all logic runs in one clock domain. It also adds buffering, overflow detection, an ordered end-of-init marker and MISO readback.

Parameters:
WORD_BITS, 16, SPI word length in bits; must be ≥ DATA_BITS+1.
DATA_BITS, 9, init payload width; the payload is word[DATA_BITS-1:0].
FIFO_DEPTH, 8, FIFO entries; must be a power of 2 and ≥ 2.
MAGIC, 16'hCAFE, test word; compared against the full WORD_BITS word.

Ports:
i_clk  in  1  system clock (48 MHz)
i_reset  in  1  asynchronous reset, active-high
i_spi_clk  in  1  SPI SCLK, mode 0, asynchronous to i_clk
i_spi_mosi  in  1  SPI MOSI
i_spi_cs  in  1  SPI chip select, active-low
o_spi_miso  out  1  MISO data
o_spi_miso_oe  out  1  MISO output enable; the top level tristates MISO when this is low
o_init_data  out  DATA_BITS  payload at the FIFO head
o_init_rdy  out  1  o_init_data is valid
i_init_ack  in  1  consumer took the head word
o_init_done  out  1  end marker has reached the FIFO head; sticky
o_magic_seen  out  1  MAGIC word received; sticky
o_overflow  out  1  a word was dropped because the FIFO was full; sticky
o_fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: all outputs are 0, the FIFO is empty, any partial word is discarded and the shift registers are cleared.
- Synchronisers: 2-FF synchronisers on SCLK, MOSI and CS; a third flop on SCLK and CS provides edge detection. Requirement: SCLK ≤ i_clk/8.
- o_spi_miso_oe is the synchronised ~CS.
- CS falling edge (synchronised):
  - bit counter = 0;
  - tx shift register loads the readback word (see Optional Feature).
- Synchronised SCLK rising edge while CS is low:
  - rx = {rx[WORD_BITS-2:0], MOSI};
  - counter increments.
  - When counter reaches WORD_BITS-1 on this edge, the completed word is decoded in the next cycle and the counter wraps to 0, so back-to-back words are allowed within one CS frame.
- Synchronised SCLK falling edge while CS is low: tx shifts left by 1; o_spi_miso = tx[WORD_BITS-1].
- CS rising mid-word: the partial word is discarded with no side effects.
- Decode of a completed word, in priority order:
  1. word == MAGIC: set o_magic_seen; the word is not pushed.
  2. end marker already queued, or done already set: the word is ignored, with no push and no overflow.
  3. word[WORD_BITS-1] == 1: push an end-marker entry.
  4. Otherwise: push a data entry containing word[DATA_BITS-1:0].
- Push onto a full FIFO: the word is dropped and o_overflow is set. If the dropped word was an end marker, it is not recorded as queued.
- FIFO entry format is {is_end, payload}.
- Head is data: o_init_rdy = 1 and o_init_data = payload. Data is registered, so o_init_rdy rises 1 cycle after the push cycle when the FIFO was empty.
- i_init_ack while o_init_rdy = 1: pop. i_init_ack while o_init_rdy = 0 is ignored.
- Head is end marker: pop it internally and set o_init_done the next cycle. o_init_rdy stays 0 from then until reset.
- Simultaneous push and pop: both occur and the level is unchanged. When full, a simultaneous pop frees a slot, so the push succeeds.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. Level goes 0..FIFO_DEPTH.

Optional Feature:
SPI_STATUS_READBACK_EN
- Defined: on CS fall, tx loads a status word: {o_overflow, o_init_done, o_magic_seen, end_queued, zero pad, o_fifo_level} in WORD_BITS bits, level in the LSBs.
- Undefined: tx loads the last completed rx word, an echo used for link test; the value is 0 after reset.

Test Plan:
- Stream 3 words 16'h0012, 16'h0155, 16'h8000 with ack tied high → o_init_data sequence 9'h012 then 9'h155; o_init_done = 1; o_overflow = 0.
- With ack held 0, send 9 data words (FIFO_DEPTH = 8) → o_fifo_level = 8, o_overflow = 1; after 8 acks the words read are 1..8 and the 9th is absent.
- Send 16'hCAFE → o_magic_seen = 1; o_fifo_level unchanged; o_init_done = 0.
- Send 8 bits then raise CS, then a full word 16'h0077 → only 9'h077 is queued.
- Hold ack 0 with 2 data words and the end marker queued → o_init_done stays 0 until both data words are acked, then rises; a later word 16'h0001 is ignored.
- Readback: with the macro defined, after 3 queued words a new frame returns 16'h0003 on MISO. Without the macro, it returns the previous word, e.g. 16'h0155. Assert i_reset mid-frame → all outputs are 0.
